// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared enums for the stream multiplexer
package mux_pkg;

    typedef enum logic {
        MUX_FIXED = 1'b0,
        MUX_RR    = 1'b1
    } mux_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request picker starting at a priority pointer
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);

    int               c;
    logic [IDX_W-1:0] c_idx;

    // Scan upward from the pointer with wrap-around and take the first requester.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        c_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c     = (int'(ptr_i) + i) % NUM_CH;
            c_idx = c[IDX_W-1:0];
            if (!valid_o && req_i[c_idx]) begin
                valid_o        = 1'b1;
                idx_o          = c_idx;
                grant_o[c_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - packet-aware N:1 stream multiplexer with registered output
module stream_mux
    import mux_pkg::*;
#(
    parameter  int        DATA_WIDTH = 32,
    parameter  int        NUM_CH     = 4,
    parameter  mux_mode_e MODE       = MUX_RR,
    localparam int        IDX_W      = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IDX_W-1:0]             sel,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_last,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic [IDX_W-1:0]             out_ch,
    input  logic                         out_ready
);

    lock_state_e           state_q, state_d;
    logic [IDX_W-1:0]      lock_ch_q, lock_ch_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [IDX_W-1:0]      out_ch_q, out_ch_d;

    logic [NUM_CH-1:0]     rr_grant;
    logic [IDX_W-1:0]      rr_idx;
    logic                  rr_vld;

    logic [IDX_W-1:0]      grant_idx;
    logic [NUM_CH-1:0]     grant_oh;
    logic                  grant_vld;
    logic                  can_load;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_data;

    if (MODE == MUX_RR) begin : g_rr
        rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
            .req_i   (in_valid),
            .ptr_i   (ptr_q),
            .grant_o (rr_grant),
            .idx_o   (rr_idx),
            .valid_o (rr_vld)
        );
    end else begin : g_fixed
        assign rr_grant = '0;
        assign rr_idx   = '0;
        assign rr_vld   = 1'b0;
    end

    // A locked packet owns the grant; otherwise sel or the arbiter picks the channel.
    always_comb begin
        grant_idx = '0;
        grant_oh  = '0;
        grant_vld = 1'b0;
        if (state_q == LOCKED) begin
            grant_idx           = lock_ch_q;
            grant_oh[lock_ch_q] = 1'b1;
            grant_vld           = in_valid[lock_ch_q];
        end else if (MODE == MUX_FIXED) begin
            grant_idx     = sel;
            grant_oh[sel] = 1'b1;
            grant_vld     = in_valid[sel];
        end else begin
            grant_idx = rr_idx;
            grant_oh  = rr_grant;
            grant_vld = rr_vld;
        end
    end

    // Payload of the granted channel.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign can_load = !out_valid_q || out_ready;
    assign xfer     = rst_n && grant_vld && can_load;
    assign in_ready = xfer ? grant_oh : '0;

    // Next output register contents, lock state and round-robin pointer.
    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (can_load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = sel_data;
                out_last_d = in_last[grant_idx];
                out_ch_d   = grant_idx;
            end
        end
        if (xfer) begin
            if (in_last[grant_idx]) begin
                state_d = IDLE;
                ptr_d   = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                state_d   = LOCKED;
                lock_ch_d = grant_idx;
            end
        end
    end

    // All state registers; reset drops any lock and empties the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - randomized and directed checks of stream_mux in both modes
module tb_stream_mux;
    import mux_pkg::*;

    localparam int DW = 32;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      sel = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_last = '0;
    logic [N*DW-1:0] in_data = '0;
    logic            out_ready = 1'b1;

    logic [N-1:0]    rr_rdy, fx_rdy;
    logic            rr_ov, fx_ov, rr_ol, fx_ol;
    logic [DW-1:0]   rr_od, fx_od;
    logic [1:0]      rr_oc, fx_oc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 = round-robin instance, 1 = fixed instance.
    bit            mv[2];
    logic [DW-1:0] md[2];
    bit            ml[2];
    int            mc[2];
    bit            lk[2];
    int            lch[2];
    int            mptr[2];
    string         nm[2] = '{"rr", "fx"};

    always #5 clk = ~clk;

    stream_mux #(.DATA_WIDTH(DW), .NUM_CH(N), .MODE(MUX_RR)) dut_rr (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rr_rdy), .out_valid(rr_ov), .out_data(rr_od),
        .out_last(rr_ol), .out_ch(rr_oc), .out_ready(out_ready)
    );

    stream_mux #(.DATA_WIDTH(DW), .NUM_CH(N), .MODE(MUX_FIXED)) dut_fx (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(fx_rdy), .out_valid(fx_ov), .out_data(fx_od),
        .out_last(fx_ol), .out_ch(fx_oc), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 0; md[m] = '0; ml[m] = 0; mc[m] = 0;
            lk[m] = 0; lch[m] = 0; mptr[m] = 0;
        end
    endtask

    // Which channel the rules say is granted this cycle, -1 when none.
    function automatic int pick(int m);
        if (lk[m]) return in_valid[lch[m]] ? lch[m] : -1;
        if (m == 1) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 0; k < N; k++) begin
            int c = (mptr[m] + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Called just after a falling edge with inputs set; leaves at the next falling edge.
    task automatic cyc();
        int g[2];
        bit space[2];
        #1;
        for (int m = 0; m < 2; m++) begin
            g[m]     = pick(m);
            space[m] = !mv[m] || out_ready;
            check({nm[m], "_ready"}, m ? fx_rdy : rr_rdy,
                  (g[m] >= 0 && space[m]) ? (64'd1 << g[m]) : 64'd0);
            check({nm[m], "_out_valid"}, m ? fx_ov : rr_ov, mv[m]);
            if (mv[m]) begin
                check({nm[m], "_out_data"}, m ? fx_od : rr_od, md[m]);
                check({nm[m], "_out_last"}, m ? fx_ol : rr_ol, ml[m]);
                check({nm[m], "_out_ch"}, m ? fx_oc : rr_oc, mc[m]);
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (space[m]) begin
                if (g[m] >= 0) begin
                    mv[m] = 1;
                    md[m] = in_data[g[m]*DW +: DW];
                    ml[m] = in_last[g[m]];
                    mc[m] = g[m];
                    if (in_last[g[m]]) begin
                        lk[m]   = 0;
                        mptr[m] = (g[m] + 1) % N;
                    end else begin
                        lk[m]  = 1;
                        lch[m] = g[m];
                    end
                end else begin
                    mv[m] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = '1; in_last = '1; out_ready = 1;
        #1;
        check("rst_rr_out_valid", rr_ov, 0);
        check("rst_fx_out_valid", fx_ov, 0);
        check("rst_rr_ready", rr_rdy, 0);
        check("rst_fx_ready", fx_rdy, 0);
        check("rst_rr_out_data", rr_od, 0);
        check("rst_rr_out_ch", rr_oc, 0);
        check("rst_fx_out_last", fx_ol, 0);
        @(negedge clk);
        rst_n = 1; in_valid = '0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Round-robin over four always-valid single-beat channels.
        in_valid = 4'hF; in_last = 4'hF; out_ready = 1; sel = 0;
        for (int k = 0; k < 6; k++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (k >= 1) begin
                check("rr_seq_valid", rr_ov, 1);
                check("rr_seq_ch", rr_oc, (k - 1) % 4);
            end
            cyc();
        end

        // Round-robin: ch1 3-beat packet holds the grant against ch0/ch2.
        do_reset();
        in_valid = 4'b0001; in_last = 4'hF;
        cyc();
        in_valid = 4'b0111; in_last = 4'b0101;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) in_last = 4'b0111;
            #1; check("rr_lock_ready", rr_rdy, 4'b0010);
            cyc();
        end
        #1; check("rr_after_lock", rr_rdy, 4'b0100);
        cyc();

        // Fixed select of channel 2, then downstream stall.
        do_reset();
        sel = 2; in_valid = 4'b0100; in_last = 4'hF;
        in_data[2*DW +: DW] = 32'hDEADBEEF;
        #1; check("fx_sel2_ready", fx_rdy, 4'b0100);
        cyc();
        #1; check("fx_sel2_data", fx_od, 32'hDEADBEEF);
        check("fx_sel2_ch", fx_oc, 2);
        out_ready = 0;
        in_data[2*DW +: DW] = 32'h12345678;
        for (int k = 0; k < 5; k++) begin
            #1; check("stall_data", fx_od, 32'hDEADBEEF);
            check("stall_ready", fx_rdy, 4'b0000);
            cyc();
        end
        out_ready = 1;
        #1; check("unstall_ready", fx_rdy, 4'b0100);
        cyc();
        #1; check("unstall_data", fx_od, 32'h12345678);
        cyc();

        // Fixed: sel moves 1 -> 3 while ch1 packet is in flight.
        do_reset();
        sel = 1; in_valid = 4'b1010; in_last = 4'b1000;
        for (int b = 0; b < 3; b++) begin
            if (b == 1) sel = 3;
            if (b == 2) in_last = 4'b1010;
            #1; check("fx_lock_ready", fx_rdy, 4'b0010);
            cyc();
        end
        #1; check("fx_after_lock", fx_rdy, 4'b1000);
        cyc();

        // Asynchronous reset in the middle of a locked packet.
        do_reset();
        in_valid = 4'b0100; in_last = 4'b0000; sel = 2;
        cyc();
        cyc();
        #2; rst_n = 0;
        #1;
        check("async_rr_out_valid", rr_ov, 0);
        check("async_fx_out_valid", fx_ov, 0);
        check("async_rr_ready", rr_rdy, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        in_valid = 4'hF; in_last = 4'hF;
        #1; check("async_ptr0", rr_rdy, 4'b0001);
        cyc();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            in_valid  = N'($urandom);
            in_last   = N'($urandom | $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom);
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
